// File: rtl/serializador_secuencia_pkg.sv
// Shared definitions for the serializer slice.
//   REPOSO / DESPLAZA : FSM state encoding (idle / shifting a word out)
//   clog2_min1        : counter width helper, never returns less than 1
package serializador_secuencia_pkg;

    localparam logic REPOSO   = 1'b0;
    localparam logic DESPLAZA = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializador_secuencia_if.sv
// Word handshake plus serial output bundle of the serializer.
//   palabra : word to serialize (master -> slave)
//   valido  : word present on palabra (master -> slave)
//   listo   : serializer can take a word this cycle (slave -> master)
//   dato    : serial bit stream, MSB first (slave -> master)
//   ocupado : a word is being shifted out (slave -> master)
//   fin     : last clock of the last bit of a word (slave -> master)
interface serializador_secuencia_if #(
    parameter int ANCHO = 8
);
    logic [ANCHO-1:0] palabra;
    logic             valido;
    logic             listo;
    logic             dato;
    logic             ocupado;
    logic             fin;

    modport master (
        output palabra, valido,
        input  listo, dato, ocupado, fin
    );

    modport slave (
        input  palabra, valido,
        output listo, dato, ocupado, fin
    );
endinterface

// File: rtl/serializador_secuencia_contador_bit.sv
// Modulo-N counter with clear, enable and terminal-count flag.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by one, wrapping from N-1 to 0
//   cnt        : current count
//   tc         : count equals N-1
module contador_bit
    import serializador_secuencia_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    output logic [clog2_min1(N)-1:0] cnt,
    output logic                     tc
);
    localparam int W = clog2_min1(N);
    localparam logic [W-1:0] ULTIMO = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + W'(1);
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == ULTIMO);
endmodule

// File: rtl/serializador_secuencia.sv
// Parallel-to-serial stage feeding detector_secuencia.dato.
// Takes an ANCHO-bit word on a valid/ready handshake and shifts it out
// MSB first, each bit held CICLOS_BIT clocks; a new word can be accepted
// in the last cycle of the current one so consecutive words have no gap.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of serializador_secuencia_if
//
// state    | meaning
// REPOSO   | idle, dato = 0, ready for a word
// DESPLAZA | shifting a word out on dato
module serializador_secuencia
    import serializador_secuencia_pkg::*;
#(
    parameter int ANCHO      = 8,
    parameter int CICLOS_BIT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    serializador_secuencia_if.slave bus
);
    localparam int WC = clog2_min1(CICLOS_BIT);
    localparam int WB = clog2_min1(ANCHO);

    logic             state_q, state_d;
    logic [ANCHO-1:0] shreg_q, shreg_d;
    logic [WC-1:0]    cnt_ciclo;
    logic [WB-1:0]    cnt_bit;
    logic             tc_ciclo, tc_bit;
    logic             ultimo, aceptar, listo, fin, ocupado;

    contador_bit #(.N(CICLOS_BIT)) u_cnt_ciclo (
        .clk   (clk),
        .reset (reset),
        .clr   (aceptar),
        .en    (ocupado),
        .cnt   (cnt_ciclo),
        .tc    (tc_ciclo)
    );

    contador_bit #(.N(ANCHO)) u_cnt_bit (
        .clk   (clk),
        .reset (reset),
        .clr   (aceptar),
        .en    (ocupado && tc_ciclo),
        .cnt   (cnt_bit),
        .tc    (tc_bit)
    );

    logic unused_cnt;
    assign unused_cnt = ^{cnt_ciclo, cnt_bit};

    assign ultimo  = (state_q == DESPLAZA) && tc_ciclo && tc_bit;
    assign aceptar = bus.valido && listo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= REPOSO;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REPOSO:   if (aceptar) state_d = DESPLAZA;
            DESPLAZA: if (ultimo)  state_d = aceptar ? DESPLAZA : REPOSO;
            default:  state_d = REPOSO;
        endcase
    end

    always_comb begin
        ocupado = (state_q == DESPLAZA);
        listo   = (state_q == REPOSO) || ultimo;
        fin     = ultimo;
    end

    // Zeros shift in behind the data, so the register is already all-zero
    // once the LSB has gone out and dato rests at 0 in REPOSO for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) shreg_q <= '0;
        else       shreg_q <= shreg_d;
    end

    always_comb begin
        shreg_d = shreg_q;
        if (aceptar)
            shreg_d = bus.palabra;
        else if (ocupado && tc_ciclo)
            shreg_d = {shreg_q[ANCHO-2:0], 1'b0};
    end

    assign bus.dato    = shreg_q[ANCHO-1];
    assign bus.listo   = listo;
    assign bus.ocupado = ocupado;
    assign bus.fin     = fin;
endmodule
